// File: rtl/alu_serial_rx_if.sv
// Packet delivery interface between alu_serial_rx (master) and the ALU core (slave).
interface alu_serial_rx_if #(
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = 5
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [8*MAX_BYTES-1:0] pkt_data;
  logic [CNT_W-1:0]       pkt_nbytes;
  logic [2:0]             pkt_op;
  logic [3:0]             pkt_crc;
  logic [2:0]             pkt_err;
  logic                   overrun;

  modport master (
    output pkt_valid, pkt_data, pkt_nbytes, pkt_op, pkt_crc, pkt_err, overrun,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_nbytes, pkt_op, pkt_crc, pkt_err, overrun,
    output pkt_ready
  );
endinterface

// File: rtl/alu_serial_rx.sv
// Serial packet receiver for the ALU link: 11-bit frames, variable-length packets, held output.
// Optional CRC-4 verification of command frames is enabled by defining ALU_RX_CRC_CHECK_EN.
module alu_serial_rx #(
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sin,
  alu_serial_rx_if.master pkt
);

  localparam int               ACC_W   = 8 * MAX_BYTES;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic             type_q, type_d;
  logic [7:0]       shift_q, shift_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             valid_q, valid_d;
  logic [ACC_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] nbytes_q, nbytes_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       crcf_q, crcf_d;
  logic [2:0]       err_q, err_d;
  logic             overrun_q, overrun_d;

  logic complete;
  logic frame_err;
  logic err_len;
  logic err_crc;
  logic out_free;

`ifdef ALU_RX_CRC_CHECK_EN
  logic [3:0] crc_q, crc_d;
  logic [3:0] crc_cmd;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    crc_step = {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'b0011 : 4'b0000);
  endfunction

  // Command frame in STOP: shift_q = {1'b0, op, crc}; finish the message with 1'b1 then op.
  always_comb begin
    crc_cmd = crc_step(crc_step(crc_step(crc_step(crc_q, 1'b1), shift_q[6]), shift_q[5]),
                       shift_q[4]);
    err_crc = (crc_cmd != shift_q[3:0]);
  end

  always_comb begin
    crc_d = crc_q;
    if (complete) begin
      crc_d = '0;
    end else if (state_q == S_PAYLOAD && !type_q) begin
      crc_d = crc_step(crc_q, sin);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign err_crc = 1'b0;
`endif

  // Frame/packet assembly
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    type_d    = type_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    complete  = 1'b0;
    frame_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d  = sin;
        bit_d   = '0;
        state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        shift_d = {shift_q[6:0], sin};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        if (sin) begin
          state_d = S_IDLE;
          if (type_q) begin
            complete = 1'b1;
          end else if (cnt_q < MAX_CNT) begin
            acc_d = (acc_q << 8) | ACC_W'(shift_q);
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
            if (cnt_q != SAT_CNT) cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          complete  = 1'b1;
          frame_err = 1'b1;
          state_d   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (sin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign err_len  = (cnt_q == '0) || ovf_q;
  assign out_free = !valid_q || pkt.pkt_ready;

  // Output register: load on completion when free, otherwise drop and flag overrun
  always_comb begin
    valid_d   = valid_q && !pkt.pkt_ready;
    data_d    = data_q;
    nbytes_d  = nbytes_q;
    op_d      = op_q;
    crcf_d    = crcf_q;
    err_d     = err_q;
    overrun_d = 1'b0;

    if (complete) begin
      if (out_free) begin
        valid_d  = 1'b1;
        data_d   = acc_q;
        nbytes_d = cnt_q;
        op_d     = frame_err ? 3'b000 : shift_q[6:4];
        crcf_d   = frame_err ? 4'b0000 : shift_q[3:0];
        err_d    = {!frame_err && err_crc, err_len, frame_err};
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      type_q    <= 1'b0;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      nbytes_q  <= '0;
      op_q      <= '0;
      crcf_q    <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      type_q    <= type_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      nbytes_q  <= nbytes_d;
      op_q      <= op_d;
      crcf_q    <= crcf_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign pkt.pkt_valid  = valid_q;
  assign pkt.pkt_data   = data_q;
  assign pkt.pkt_nbytes = nbytes_q;
  assign pkt.pkt_op     = op_q;
  assign pkt.pkt_crc    = crcf_q;
  assign pkt.pkt_err    = err_q;
  assign pkt.overrun    = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed testbench for alu_serial_rx; expected err_crc follows ALU_RX_CRC_CHECK_EN.
module tb_alu_serial_rx;
  localparam int MAX_BYTES = 8;
  localparam int CNT_W     = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sin   = 1'b1;

  always #5 clk = ~clk;

  alu_serial_rx_if #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) pif ();

  alu_serial_rx #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sin  (sin),
    .pkt  (pif.master)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         ovr_cnt     = 0;
  logic [7:0] tx_bytes [0:15];
  logic [3:0] exp_crc;
  logic [2:0] exp_bad_err;

  always @(negedge clk) if (pif.overrun === 1'b1) ovr_cnt++;

  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
  endtask

  // Sends n data frames from tx_bytes then a command frame; the stop bit is sampled on the next posedge.
  task automatic send_packet(input int n, input logic [2:0] op, input logic force_crc,
                             input logic [3:0] crc_val);
    logic [3:0] c;
    c = 4'b0000;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) c = crc_bit(c, tx_bytes[k][i]);
    c = crc_bit(c, 1'b1);
    for (int i = 2; i >= 0; i--) c = crc_bit(c, op[i]);
    exp_crc = force_crc ? crc_val : c;
    for (int k = 0; k < n; k++) send_frame(1'b0, tx_bytes[k], 1'b1);
    send_frame(1'b1, {1'b0, op, exp_crc}, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sin   = 1'b1;
    pif.pkt_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'h0) begin miscompares++; $display("FAIL rst_data got %h exp 0", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd0) begin miscompares++; $display("FAIL rst_nbytes got %0d exp 0", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd0) begin miscompares++; $display("FAIL rst_op got %0d exp 0", pif.pkt_op); end
    vectors++; if (pif.pkt_crc !== 4'd0) begin miscompares++; $display("FAIL rst_crc got %h exp 0", pif.pkt_crc); end
    vectors++; if (pif.pkt_err !== 3'd0) begin miscompares++; $display("FAIL rst_err got %b exp 000", pif.pkt_err); end
    vectors++; if (pif.overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b exp 0", pif.overrun); end
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_full_packet;
    for (int k = 0; k < 8; k++) tx_bytes[k] = 8'(k);
    send_packet(8, 3'b100, 1'b0, 4'b0000);
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL full_valid_early got %b exp 0", pif.pkt_valid); end
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'h0001020304050607) begin miscompares++; $display("FAIL full_data got %h exp 0001020304050607", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd8) begin miscompares++; $display("FAIL full_nbytes got %0d exp 8", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd4) begin miscompares++; $display("FAIL full_op got %0d exp 4", pif.pkt_op); end
    vectors++; if (pif.pkt_crc !== exp_crc) begin miscompares++; $display("FAIL full_crc got %h exp %h", pif.pkt_crc, exp_crc); end
    vectors++; if (pif.pkt_err !== 3'b000) begin miscompares++; $display("FAIL full_err got %b exp 000", pif.pkt_err); end
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL full_valid_width got %b exp 0", pif.pkt_valid); end
  endtask

  // Second packet starts on the cycle right after the first stop bit.
  task automatic test_crc_back_to_back;
    tx_bytes[0] = 8'h00;
    send_packet(1, 3'b000, 1'b1, 4'b1011);
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL crc_good_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_nbytes !== 5'd1) begin miscompares++; $display("FAIL crc_good_nbytes got %0d exp 1", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_err !== 3'b000) begin miscompares++; $display("FAIL crc_good_err got %b exp 000", pif.pkt_err); end
    vectors++; if (pif.pkt_crc !== 4'b1011) begin miscompares++; $display("FAIL crc_good_field got %b exp 1011", pif.pkt_crc); end
    send_packet(1, 3'b000, 1'b1, 4'b0000);
    @(posedge clk); #1;
`ifdef ALU_RX_CRC_CHECK_EN
    exp_bad_err = 3'b100;
`else
    exp_bad_err = 3'b000;
`endif
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL crc_bad_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_nbytes !== 5'd1) begin miscompares++; $display("FAIL crc_bad_nbytes got %0d exp 1", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_err !== exp_bad_err) begin miscompares++; $display("FAIL crc_bad_err got %b exp %b", pif.pkt_err, exp_bad_err); end
    vectors++; if (pif.pkt_crc !== 4'b0000) begin miscompares++; $display("FAIL crc_bad_field got %b exp 0000", pif.pkt_crc); end
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_length;
    send_packet(0, 3'b010, 1'b0, 4'b0000);
    @(posedge clk); #1;
    vectors++; if (pif.pkt_err !== 3'b010) begin miscompares++; $display("FAIL len_empty_err got %b exp 010", pif.pkt_err); end
    vectors++; if (pif.pkt_nbytes !== 5'd0) begin miscompares++; $display("FAIL len_empty_nbytes got %0d exp 0", pif.pkt_nbytes); end
    for (int k = 0; k < 9; k++) tx_bytes[k] = 8'(8'h10 + k);
    send_packet(9, 3'b011, 1'b0, 4'b0000);
    @(posedge clk); #1;
    vectors++; if (pif.pkt_err !== 3'b010) begin miscompares++; $display("FAIL len_over_err got %b exp 010", pif.pkt_err); end
    vectors++; if (pif.pkt_nbytes !== 5'd9) begin miscompares++; $display("FAIL len_over_nbytes got %0d exp 9", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_data !== 64'h1011121314151617) begin miscompares++; $display("FAIL len_over_data got %h exp 1011121314151617", pif.pkt_data); end
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_frame_error;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'hA5, 1'b0);
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL ferr_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_err !== 3'b001) begin miscompares++; $display("FAIL ferr_err got %b exp 001", pif.pkt_err); end
    vectors++; if (pif.pkt_op !== 3'd0) begin miscompares++; $display("FAIL ferr_op got %0d exp 0", pif.pkt_op); end
    vectors++; if (pif.pkt_nbytes !== 5'd1) begin miscompares++; $display("FAIL ferr_nbytes got %0d exp 1", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_data !== 64'h11) begin miscompares++; $display("FAIL ferr_data got %h exp 11", pif.pkt_data); end
    repeat (20) send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    tx_bytes[0] = 8'hDE;
    tx_bytes[1] = 8'hAD;
    send_packet(2, 3'b101, 1'b0, 4'b0000);
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL recov_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'hDEAD) begin miscompares++; $display("FAIL recov_data got %h exp dead", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd2) begin miscompares++; $display("FAIL recov_nbytes got %0d exp 2", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd5) begin miscompares++; $display("FAIL recov_op got %0d exp 5", pif.pkt_op); end
    vectors++; if (pif.pkt_err !== 3'b000) begin miscompares++; $display("FAIL recov_err got %b exp 000", pif.pkt_err); end
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_backpressure;
    logic [3:0] crc_a;
    pif.pkt_ready = 1'b0;
    ovr_cnt = 0;
    tx_bytes[0] = 8'h5A;
    send_packet(1, 3'b001, 1'b0, 4'b0000);
    crc_a = exp_crc;
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.overrun !== 1'b0) begin miscompares++; $display("FAIL bp_first_overrun got %b exp 0", pif.overrun); end
    tx_bytes[0] = 8'h33;
    tx_bytes[1] = 8'h44;
    send_packet(2, 3'b010, 1'b0, 4'b0000);
    @(posedge clk); #1;
    vectors++; if (pif.overrun !== 1'b1) begin miscompares++; $display("FAIL bp_overrun got %b exp 1", pif.overrun); end
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'h5A) begin miscompares++; $display("FAIL bp_hold_data got %h exp 5a", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd1) begin miscompares++; $display("FAIL bp_hold_nbytes got %0d exp 1", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd1) begin miscompares++; $display("FAIL bp_hold_op got %0d exp 1", pif.pkt_op); end
    vectors++; if (pif.pkt_crc !== crc_a) begin miscompares++; $display("FAIL bp_hold_crc got %h exp %h", pif.pkt_crc, crc_a); end
    @(posedge clk); #1;
    vectors++; if (pif.overrun !== 1'b0) begin miscompares++; $display("FAIL bp_overrun_width got %b exp 0", pif.overrun); end
    @(negedge clk);
    pif.pkt_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept got %b exp 0", pif.pkt_valid); end
    vectors++; if (ovr_cnt !== 1) begin miscompares++; $display("FAIL bp_overrun_count got %0d exp 1", ovr_cnt); end
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] partial;
    partial = 8'h3C;
    send_frame(1'b0, 8'h01, 1'b1);
    send_frame(1'b0, 8'h02, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(partial[i]);
    @(negedge clk);
    rst_n = 1'b0;
    sin   = 1'b1;
    #1;
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b exp 0", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'h0) begin miscompares++; $display("FAIL mid_rst_data got %h exp 0", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd0) begin miscompares++; $display("FAIL mid_rst_nbytes got %0d exp 0", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd0) begin miscompares++; $display("FAIL mid_rst_op got %0d exp 0", pif.pkt_op); end
    vectors++; if (pif.pkt_crc !== 4'd0) begin miscompares++; $display("FAIL mid_rst_crc got %h exp 0", pif.pkt_crc); end
    vectors++; if (pif.pkt_err !== 3'd0) begin miscompares++; $display("FAIL mid_rst_err got %b exp 000", pif.pkt_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) send_bit(1'b1);
    tx_bytes[0] = 8'h77;
    send_packet(1, 3'b110, 1'b0, 4'b0000);
    vectors++; if (pif.pkt_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_partial got %b exp 0", pif.pkt_valid); end
    @(posedge clk); #1;
    vectors++; if (pif.pkt_valid !== 1'b1) begin miscompares++; $display("FAIL mid_valid got %b exp 1", pif.pkt_valid); end
    vectors++; if (pif.pkt_data !== 64'h77) begin miscompares++; $display("FAIL mid_data got %h exp 77", pif.pkt_data); end
    vectors++; if (pif.pkt_nbytes !== 5'd1) begin miscompares++; $display("FAIL mid_nbytes got %0d exp 1", pif.pkt_nbytes); end
    vectors++; if (pif.pkt_op !== 3'd6) begin miscompares++; $display("FAIL mid_op got %0d exp 6", pif.pkt_op); end
    vectors++; if (pif.pkt_err !== 3'b000) begin miscompares++; $display("FAIL mid_err got %b exp 000", pif.pkt_err); end
    repeat (2) send_bit(1'b1);
  endtask

  initial begin
    pif.pkt_ready = 1'b1;
    test_reset();
    test_full_packet();
    test_crc_back_to_back();
    test_length();
    test_frame_error();
    test_backpressure();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
